// File: rtl/board_pkg.sv
// Shared constants for the board shift engine: direction encodings,
// default board geometry and the engine state encoding.
package board_pkg;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 4;

  localparam logic [1:0] DIR_UL = 2'b00;
  localparam logic [1:0] DIR_UR = 2'b01;
  localparam logic [1:0] DIR_DL = 2'b10;
  localparam logic [1:0] DIR_DR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/board_step.sv
// Combinational single-square diagonal shift of a board; squares with no
// source inside the board take FILL.
module board_step
  import board_pkg::*;
#(
  parameter int   ROWS = BOARD_ROWS,
  parameter int   COLS = BOARD_COLS,
  parameter logic FILL = 1'b1,
  localparam int  N    = ROWS * COLS
) (
  input  logic [1:0]   dir,
  input  logic [N-1:0] in_board,
  output logic [N-1:0] out_board
);

  // Per square, build all four candidate sources and pick one by direction.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] cand_s;

      if (r < ROWS - 1 && c < COLS - 1) begin : g_ul
        assign cand_s[DIR_UL] = in_board[(r + 1) * COLS + c];
      end else begin : g_ul_fill
        assign cand_s[DIR_UL] = FILL;
      end

      if (r < ROWS - 1 && c > 0) begin : g_ur
        assign cand_s[DIR_UR] = in_board[(r + 1) * COLS + c - 1];
      end else begin : g_ur_fill
        assign cand_s[DIR_UR] = FILL;
      end

      if (r > 0 && c < COLS - 1) begin : g_dl
        assign cand_s[DIR_DL] = in_board[(r - 1) * COLS + c];
      end else begin : g_dl_fill
        assign cand_s[DIR_DL] = FILL;
      end

      if (r > 0 && c > 0) begin : g_dr
        assign cand_s[DIR_DR] = in_board[(r - 1) * COLS + c - 1];
      end else begin : g_dr_fill
        assign cand_s[DIR_DR] = FILL;
      end

      assign out_board[r * COLS + c] = cand_s[dir];
    end
  end

endmodule

// File: rtl/board_shift_engine.sv
// Multi-step board shifter with valid/ready handshakes and flush abort.
// Optional OR-accumulator of intermediate boards: BOARD_SHIFT_ACCUM_EN.
module board_shift_engine
  import board_pkg::*;
#(
  parameter int   ROWS      = BOARD_ROWS,
  parameter int   COLS      = BOARD_COLS,
  parameter logic FILL      = 1'b1,
  parameter int   MAX_STEPS = 7,
  localparam int  N         = ROWS * COLS,
  localparam int  SW        = $clog2(MAX_STEPS + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_board,
  input  logic [1:0]    in_dir,
  input  logic [SW-1:0] in_steps,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_board,
  output logic [N-1:0]  out_accum,
  output logic          busy
);

  state_e        state_r, state_nx_s;
  logic [N-1:0]  board_r, step_s;
  logic [1:0]    dir_r;
  logic [SW-1:0] count_r, k_s;
  logic          in_ready_r, out_valid_r, busy_r;
  logic          accept_s, shift_s;

  assign k_s      = (in_steps > SW'(MAX_STEPS)) ? SW'(MAX_STEPS) : in_steps;
  assign accept_s = in_valid && in_ready_r && !flush;
  assign shift_s  = (state_r == ST_SHIFT) && !flush;

  board_step #(
    .ROWS (ROWS),
    .COLS (COLS),
    .FILL (FILL)
  ) u_step (
    .dir       (dir_r),
    .in_board  (board_r),
    .out_board (step_s)
  );

  // Next-state logic; flush wins over both acceptance and the output handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else if (in_valid) begin
          state_nx_s = (k_s != SW'(0)) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else if (count_r == SW'(1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  // Request latch and one shift step per SHIFT cycle; a flush freezes the board.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board_r <= {N{1'b0}};
      dir_r   <= DIR_UL;
      count_r <= {SW{1'b0}};
    end else if (accept_s) begin
      board_r <= in_board;
      dir_r   <= in_dir;
      count_r <= k_s;
    end else if (shift_s) begin
      board_r <= step_s;
      count_r <= count_r - SW'(1);
    end
  end

`ifdef BOARD_SHIFT_ACCUM_EN
  logic [N-1:0] accum_r;

  // OR of every board produced by a step since the request was accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accum_r <= {N{1'b0}};
    end else if (accept_s) begin
      accum_r <= {N{1'b0}};
    end else if (shift_s) begin
      accum_r <= accum_r | step_s;
    end
  end

  assign out_accum = accum_r;
`else
  assign out_accum = {N{1'b0}};
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_board = board_r;

endmodule

// File: tb/tb_board_shift_engine.sv
// Directed self-checking bench for board_shift_engine at default geometry
// (8x4, FILL=1, MAX_STEPS=7); follows BOARD_SHIFT_ACCUM_EN for out_accum.
module tb_board_shift_engine;
  import board_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_board;
  logic [1:0]  in_dir;
  logic [2:0]  in_steps;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_board;
  logic [31:0] out_accum;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  board_shift_engine dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_board  (in_board),
    .in_dir    (in_dir),
    .in_steps  (in_steps),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_board (out_board),
    .out_accum (out_accum),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_exp(input logic [31:0] v);
`ifdef BOARD_SHIFT_ACCUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] b, input logic [1:0] d, input logic [2:0] s);
    check("ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    in_board = b;
    in_dir   = d;
    in_steps = s;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Cycles from acceptance until out_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] b, input logic [1:0] d,
                     input logic [2:0] s, input logic [31:0] exp_board,
                     input logic [31:0] exp_acc_raw, input int exp_lat);
    int lat;
    issue(b, d, s);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_board"}, out_board, exp_board);
    check({tag, "_accum"}, out_accum, acc_exp(exp_acc_raw));
    @(negedge clock);
    check({tag, "_consumed"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int seen_valid;
    logic [31:0] held;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_board  = 32'h0;
    in_dir    = DIR_UL;
    in_steps  = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_board", out_board, 32'h0);
    check("rst_out_accum", out_accum, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    run("ul1_zero", 32'h0000_0000, DIR_UL, 3'd1, 32'hF888_8888, 32'hF888_8888, 2);
    run("ul1_bit4", 32'h0000_0010, DIR_UL, 3'd1, 32'hF888_8889, 32'hF888_8889, 2);
    run("ul2_zero", 32'h0000_0000, DIR_UL, 3'd2, 32'hFF88_8888, 32'hFF88_8888, 3);
    run("steps0",   32'h1234_5678, DIR_DR, 3'd0, 32'h1234_5678, 32'h0000_0000, 1);
    run("ur1_bit4", 32'h0000_0010, DIR_UR, 3'd1, 32'hF111_1113, 32'hF111_1113, 2);
    run("dl1_bit0", 32'h0000_0001, DIR_DL, 3'd1, 32'h8888_889F, 32'h8888_889F, 2);
    run("dr1_bit0", 32'h0000_0001, DIR_DR, 3'd1, 32'h1111_113F, 32'h1111_113F, 2);
    run("ul7_max",  32'h0000_0000, DIR_UL, 3'd7, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 8);

    // Consumer stalls for five cycles while new requests are offered.
    out_ready = 1'b0;
    begin
      int lat;
      issue(32'h1234_5678, DIR_UL, 3'd0);
      wait_valid(lat);
      check("stall_lat", lat, 1);
    end
    held = out_board;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_board = 32'hDEAD_BEEF;
      in_steps = 3'd0;
      @(negedge clock);
      check("stall_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_board", out_board, 32'h1234_5678);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("stall_consumed", {in_ready, out_valid, busy}, 3'b100);
    check("stall_no_overlap", out_board, held);
    @(negedge clock);
    check("stall_still_idle", {in_ready, out_valid, busy}, 3'b100);

    // Asynchronous reset in the second SHIFT cycle.
    issue(32'h0000_0000, DIR_UL, 3'd5);
    @(negedge clock);
    check("rstmid_shifting", {in_ready, out_valid, busy}, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_in_ready", in_ready, 1'b1);
    check("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_board", out_board, 32'h0);
    check("rstmid_accum", out_accum, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rstmid_after", {in_ready, out_valid, busy}, 3'b100);

    // Flush in the second SHIFT cycle.
    issue(32'h0000_0000, DIR_UL, 3'd5);
    @(negedge clock);
    check("flush_board_1step", out_board, 32'hF888_8888);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_idle", {in_ready, out_valid, busy}, 3'b100);
    check("flush_board_kept", out_board, 32'hF888_8888);
    check("flush_accum_kept", out_accum, acc_exp(32'hF888_8888));
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) seen_valid = 1;
    end
    check("flush_no_valid", seen_valid, 0);

    // Flush beats acceptance in IDLE.
    in_valid = 1'b1;
    flush    = 1'b1;
    in_board = 32'hAAAA_AAAA;
    in_steps = 3'd0;
    @(negedge clock);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_accept_state", {in_ready, out_valid, busy}, 3'b100);
    check("flush_vs_accept_board", out_board, 32'hF888_8888);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_shift_engine.md
BOARD_SHIFT_ENGINE -- requirements
Module: board_shift_engine

Interface
REQ-001 The block SHALL have these parameters: ROWS, default 8, board rows; COLS, default 4, playable squares per row; FILL, default 1'b1, value written into vacated border squares; MAX_STEPS, default 7, largest shift count. Derived: N = ROWS*COLS; SW = clog2(MAX_STEPS+1).
REQ-002 clock  input  1  Sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  Asynchronous, active-low reset.
REQ-004 in_valid  input  1  Request present.
REQ-005 in_ready  output  1  Engine can accept a request.
REQ-006 in_board  input  N  Board bit-vector; square index i = r*COLS+c, with r=0 the top row and c=0 the leftmost square.
REQ-007 in_dir  input  2  Shift direction: 00 UL, 01 UR, 10 DL, 11 DR.
REQ-008 in_steps  input  SW  Number of single-square shifts to apply.
REQ-009 flush  input  1  Synchronous abort.
REQ-010 out_valid  output  1  Result available.
REQ-011 out_ready  input  1  Consumer accepts the result.
REQ-012 out_board  output  N  Shifted board.
REQ-013 out_accum  output  N  OR of every intermediate shifted board (see Configuration).
REQ-014 busy  output  1  High whenever the state is not IDLE.

Function
REQ-015 One shift step SHALL be defined as follows; any position outside these ranges SHALL take FILL:
- UL: out[r][c] = in[r+1][c], for r<ROWS-1 and c<COLS-1.
- UR: out[r][c] = in[r+1][c-1], for r<ROWS-1 and c>0.
- DL: out[r][c] = in[r-1][c], for r>0 and c<COLS-1.
- DR: out[r][c] = in[r-1][c-1], for r>0 and c>0.
REQ-016 The FSM SHALL have three states, IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE).
REQ-017 Acceptance SHALL occur when in_valid && in_ready is sampled high. On acceptance the block SHALL latch in_board, in_dir and k = min(in_steps, MAX_STEPS), and clear the accumulator. The next state SHALL be SHIFT if k>0, otherwise DONE.
REQ-018 In SHIFT, the block SHALL apply exactly one step per cycle and decrement the count. After the k-th step the next state SHALL be DONE.
REQ-019 Latency: for acceptance in cycle C, out_valid SHALL first be high in cycle C+1+k.
REQ-020 In DONE, out_valid SHALL be 1, and out_board and out_accum SHALL be held stable until out_ready is high.
REQ-021 On out_valid && out_ready the next state SHALL be IDLE, with no result overlap: in_ready SHALL stay low during DONE, so a new request is accepted no earlier than the following cycle.
REQ-022 While in IDLE or SHIFT, out_valid SHALL be 0; in_valid SHALL be ignored whenever in_ready is 0.
REQ-023 flush=1 SHALL force the next state to IDLE from any state; flush SHALL take priority over acceptance and over an out handshake in the same cycle. out_board and out_accum SHALL retain their last values.
REQ-024 A value of in_steps greater than MAX_STEPS SHALL be clamped to MAX_STEPS; this SHALL produce no error indication.

Reset
REQ-025 While reset_n is low, the block SHALL hold: state=IDLE, in_ready=1, out_valid=0, busy=0, out_board=0, out_accum=0, count=0.
REQ-026 A reset asserted mid-SHIFT or mid-DONE SHALL discard the operation immediately, asynchronously.

Configuration
REQ-027 The macro is BOARD_SHIFT_ACCUM_EN.
- Defined: out_accum SHALL be the OR of the boards produced by steps 1..k, and SHALL be 0 when k=0.
- Undefined: the accumulator register SHALL be omitted and out_accum SHALL be tied to 0; the port SHALL remain.

Structure
REQ-028 A shared package board_pkg SHALL hold the direction encoding constants DIR_UL, DIR_UR, DIR_DL and DIR_DR, and the default ROWS/COLS.
REQ-029 The combinational single-step function SHALL be a sub-module, board_step, parametrised by ROWS, COLS and FILL with dir as an input. The FSM, counter and registers SHALL stay in board_shift_engine.

Verification (defaults, FILL=1)
REQ-030 board=0, dir=UL, steps=1 -> out_board=32'hF8888888 in cycle C+2.
REQ-031 board=32'h00000010, dir=UL, steps=1 -> out_board=32'hF8888889.
REQ-032 With ACCUM_EN defined: board=0, dir=UL, steps=2 -> out_board=32'hFF888888, out_accum=32'hFF888888, out_valid in cycle C+3.
REQ-033 board=32'h12345678, steps=0 -> out_board=32'h12345678 in cycle C+1, and out_accum=0.
REQ-034 out_ready is held low for 5 cycles while in_valid pulses -> result stable, in_ready=0, no new request accepted, and the result is consumed on the cycle out_ready rises.
REQ-035 Two cases, each checked: (a) reset_n pulsed low in the second cycle of SHIFT with steps=5 -> all outputs at reset values; (b) flush asserted in the same position, no reset -> IDLE next cycle, out_valid never asserted.
